fdiv_sched: RTL and testbench

Request scheduler and iteration sequencer for the shared Goldschmidt mantissa divider. Two requesters (e.g. two FP divide pipes) compete for a single `goldschmidt_div` datapath. The block round-robin arbitrates between them, latches the winner's mantissae, and drives the datapath's `mode`/`stage` through one load step and `ITERS` two-stage iterations. It then normalises (and optionally rounds) the quotient and returns it tagged with the requester id.

---
 rtl/fdiv_sched.sv | 207 ++++++++++++++++++++
 tb/tb_fdiv_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_sched.sv
// Round-robin scheduler and mode/stage sequencer for a shared Goldschmidt mantissa divider.
// Optional round-to-nearest-even of the returned quotient: define FDIV_SCHED_ROUND_EN.
module fdiv_sched #(
   parameter int WIDTH = 23,
   parameter int ITERS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_m1,
   input  logic [WIDTH-1:0] req0_m2,
   input  logic [WIDTH-1:0] req1_m1,
   input  logic [WIDTH-1:0] req1_m2,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [WIDTH-1:0] res_m3,
   output logic             res_decrement_exponent,
   output logic             busy,
   output logic             dp_mode,
   output logic             dp_stage,
   output logic [WIDTH+4:0] dp_numerator,
   output logic [WIDTH+4:0] dp_denominator,
   input  logic [WIDTH+4:0] dp_quotient
);

   localparam int QW   = WIDTH + 5;
   localparam int NCYC = 2 * ITERS;
   localparam int CW   = $clog2(2 * ITERS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [QW-1:0]    num_q, num_d;
   logic [QW-1:0]    den_q, den_d;
   logic             res_valid_q, res_valid_d;
   logic             res_id_q, res_id_d;
   logic [WIDTH-1:0] res_m3_q, res_m3_d;
   logic             res_dec_q, res_dec_d;
   logic             busy_q, busy_d;
   logic             mode_q, mode_d;
   logic             stage_q, stage_d;

   logic [1:0]       grant;
   logic             accept;
   logic             sel;
   logic [WIDTH-1:0] mant_raw;
   logic [2:0]       guard;
   logic             dec_raw;
   logic [WIDTH-1:0] mant_fin;
   logic             dec_fin;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      grant = 2'b00;
      if (state_q == IDLE) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);
   assign sel       = grant[1];

   always_comb begin
      if (dp_quotient[WIDTH+3]) begin
         dec_raw  = 1'b0;
         mant_raw = dp_quotient[WIDTH+2:3];
         guard    = dp_quotient[2:0];
      end else begin
         dec_raw  = 1'b1;
         mant_raw = dp_quotient[WIDTH+1:2];
         guard    = {dp_quotient[1:0], 1'b0};
      end
   end

`ifdef FDIV_SCHED_ROUND_EN
   logic             rnd_inc;
   logic [WIDTH:0]   mant_sum;

   assign rnd_inc  = guard[2] & ((|guard[1:0]) | mant_raw[0]);
   assign mant_sum = {1'b0, mant_raw} + {{WIDTH{1'b0}}, rnd_inc};

   // A carry out means the rounded quotient is exactly 1.0.
   always_comb begin
      if (mant_sum[WIDTH]) begin
         mant_fin = '0;
         dec_fin  = 1'b0;
      end else begin
         mant_fin = mant_sum[WIDTH-1:0];
         dec_fin  = dec_raw;
      end
   end

   logic unused_bits;
   assign unused_bits = dp_quotient[WIDTH+4];
`else
   assign mant_fin = mant_raw;
   assign dec_fin  = dec_raw;

   logic unused_bits;
   assign unused_bits = ^{dp_quotient[WIDTH+4], guard};
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      num_d     = num_q;
      den_d     = den_q;
      res_id_d  = res_id_q;
      res_m3_d  = res_m3_q;
      res_dec_d = res_dec_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = LOAD;
               res_id_d = sel;
               num_d    = {1'b1, (sel ? req1_m1 : req0_m1), 3'b000};
               den_d    = {1'b1, (sel ? req1_m2 : req0_m2), 3'b000};
            end
         end
         LOAD: begin
            state_d = ITER;
            cnt_d   = '0;
         end
         ITER: begin
            if (cnt_q == LAST_CNT) begin
               state_d   = RESP;
               res_m3_d  = mant_fin;
               res_dec_d = dec_fin;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (res_ready) begin
               state_d = IDLE;
               last_d  = res_id_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Control outputs are registered, so they are computed from the next state.
      busy_d      = (state_d != IDLE);
      res_valid_d = (state_d == RESP);
      mode_d      = (state_d == ITER);
      stage_d     = (state_d == ITER) && cnt_d[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         num_q       <= '0;
         den_q       <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
         res_m3_q    <= '0;
         res_dec_q   <= 1'b0;
         busy_q      <= 1'b0;
         mode_q      <= 1'b0;
         stage_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         num_q       <= num_d;
         den_q       <= den_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_m3_q    <= res_m3_d;
         res_dec_q   <= res_dec_d;
         busy_q      <= busy_d;
         mode_q      <= mode_d;
         stage_q     <= stage_d;
      end
   end

   assign res_valid              = res_valid_q;
   assign res_id                 = res_id_q;
   assign res_m3                 = res_m3_q;
   assign res_decrement_exponent = res_dec_q;
   assign busy                   = busy_q;
   assign dp_mode                = mode_q;
   assign dp_stage               = stage_q;
   assign dp_numerator           = num_q;
   assign dp_denominator         = den_q;

endmodule

// File: tb/tb_fdiv_sched.sv
// Randomised self-checking bench for fdiv_sched with an arithmetic divider/arbiter reference.
module tb_fdiv_sched;
   localparam int WIDTH = 23;
   localparam int ITERS = 3;
   localparam int QW    = WIDTH + 5;
   localparam int NCYC  = 2 * ITERS;

   logic             clk;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req0_m1, req0_m2, req1_m1, req1_m2;
   logic             res_valid;
   logic             res_ready;
   logic             res_id;
   logic [WIDTH-1:0] res_m3;
   logic             res_decrement_exponent;
   logic             busy;
   logic             dp_mode, dp_stage;
   logic [QW-1:0]    dp_numerator, dp_denominator, dp_quotient;

   fdiv_sched #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_m1(req0_m1), .req0_m2(req0_m2), .req1_m1(req1_m1), .req1_m2(req1_m2),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_m3(res_m3),
      .res_decrement_exponent(res_decrement_exponent), .busy(busy),
      .dp_mode(dp_mode), .dp_stage(dp_stage),
      .dp_numerator(dp_numerator), .dp_denominator(dp_denominator),
      .dp_quotient(dp_quotient)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] op_m1 [2];
   logic [WIDTH-1:0] op_m2 [2];
   int last_served = 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Exact truncated quotient of 1.m1 / 1.m2 with weight-1 bit at WIDTH+3.
   function automatic logic [QW-1:0] exact_quot(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint unsigned n, d;
      n = (64'd1 << WIDTH) + 64'(a);
      d = (64'd1 << WIDTH) + 64'(b);
      return QW'((n << (WIDTH + 3)) / d);
   endfunction

   task automatic ref_result(input logic [QW-1:0] q, output logic [WIDTH-1:0] m3, output logic dec);
      longint unsigned qv, mant, g;
      qv = 64'(q);
      if (qv >= (64'd1 << (WIDTH + 3))) begin
         dec  = 1'b0;
         mant = (qv / 8) % (64'd1 << WIDTH);
         g    = qv % 8;
      end else begin
         dec  = 1'b1;
         mant = (qv / 4) % (64'd1 << WIDTH);
         g    = (qv % 4) * 2;
      end
`ifdef FDIV_SCHED_ROUND_EN
      if (g > 4 || (g == 4 && mant % 2 == 1)) mant = mant + 1;
      if (mant == (64'd1 << WIDTH)) begin
         mant = 0;
         dec  = 1'b0;
      end
`else
      g = 0;
`endif
      m3 = WIDTH'(mant);
   endtask

   function automatic logic [1:0] exp_grant(input logic [1:0] v);
      if (v == 2'b11) return (last_served == 1) ? 2'b01 : 2'b10;
      return v;
   endfunction

   task automatic check_reset_state(input string tag);
      check_val({tag, "/req_ready"}, 64'(req_ready), 64'd0);
      check_val({tag, "/res_valid"}, 64'(res_valid), 64'd0);
      check_val({tag, "/res_id"},    64'(res_id), 64'd0);
      check_val({tag, "/res_m3"},    64'(res_m3), 64'd0);
      check_val({tag, "/dec"},       64'(res_decrement_exponent), 64'd0);
      check_val({tag, "/busy"},      64'(busy), 64'd0);
      check_val({tag, "/mode"},      64'(dp_mode), 64'd0);
      check_val({tag, "/stage"},     64'(dp_stage), 64'd0);
      check_val({tag, "/num"},       64'(dp_numerator), 64'd0);
      check_val({tag, "/den"},       64'(dp_denominator), 64'd0);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
   task automatic run_divide(input logic [1:0] valid, input int stall, input int abort_k, input string tag);
      logic [1:0]       g;
      int               id;
      logic [QW-1:0]    q, exp_num, exp_den;
      logic [WIDTH-1:0] em3;
      logic             edec;
      req_valid = valid;
      req0_m1 = op_m1[0]; req0_m2 = op_m2[0];
      req1_m1 = op_m1[1]; req1_m2 = op_m2[1];
      res_ready = 1'b0;
      #1;
      g  = exp_grant(valid);
      id = (g == 2'b10) ? 1 : 0;
      check_val({tag, "/grant"}, 64'(req_ready), 64'(g));
      check_val({tag, "/idle_busy"}, 64'(busy), 64'd0);
      exp_num = {1'b1, op_m1[id], 3'b000};
      exp_den = {1'b1, op_m2[id], 3'b000};
      q = exact_quot(op_m1[id], op_m2[id]);
      ref_result(q, em3, edec);
      @(posedge clk);
      #1;
      req_valid = 2'($urandom);
      req0_m1 = WIDTH'($urandom); req0_m2 = WIDTH'($urandom);
      req1_m1 = WIDTH'($urandom); req1_m2 = WIDTH'($urandom);
      for (int k = 1; k <= NCYC + 1; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            reset = 1'b1;
            req_valid = 2'b00;
            #1;
            check_reset_state({tag, "/midreset"});
            @(negedge clk);
            reset = 1'b0;
            last_served = 1;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               check_val({tag, "/no_resp"}, 64'(res_valid), 64'd0);
            end
            return;
         end
         check_val($sformatf("%s/mode%0d", tag, k), 64'(dp_mode), (k == 1) ? 64'd0 : 64'd1);
         check_val($sformatf("%s/stage%0d", tag, k), 64'(dp_stage), (k > 1 && k % 2 == 1) ? 64'd1 : 64'd0);
         check_val($sformatf("%s/busy%0d", tag, k), 64'(busy), 64'd1);
         check_val($sformatf("%s/rdy%0d", tag, k), 64'(req_ready), 64'd0);
         check_val($sformatf("%s/vld%0d", tag, k), 64'(res_valid), 64'd0);
         check_val($sformatf("%s/num%0d", tag, k), 64'(dp_numerator), 64'(exp_num));
         check_val($sformatf("%s/den%0d", tag, k), 64'(dp_denominator), 64'(exp_den));
         dp_quotient = (k == NCYC + 1) ? q : QW'($urandom);
         res_ready = 1'($urandom);
         req_valid = 2'($urandom);
      end
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         check_val($sformatf("%s/res_valid%0d", tag, s), 64'(res_valid), 64'd1);
         check_val($sformatf("%s/res_id%0d", tag, s), 64'(res_id), 64'(id));
         check_val($sformatf("%s/res_m3_%0d", tag, s), 64'(res_m3), 64'(em3));
         check_val($sformatf("%s/dec%0d", tag, s), 64'(res_decrement_exponent), 64'(edec));
         check_val($sformatf("%s/resp_busy%0d", tag, s), 64'(busy), 64'd1);
         check_val($sformatf("%s/resp_mode%0d", tag, s), 64'({dp_mode, dp_stage}), 64'd0);
         check_val($sformatf("%s/resp_rdy%0d", tag, s), 64'(req_ready), 64'd0);
         dp_quotient = QW'($urandom);
         req_valid = 2'($urandom);
         res_ready = (s == stall);
      end
      @(negedge clk);
      check_val({tag, "/back_idle_vld"}, 64'(res_valid), 64'd0);
      check_val({tag, "/back_idle_busy"}, 64'(busy), 64'd0);
      last_served = id;
      req_valid = 2'b00;
      res_ready = 1'b0;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 2; i++) begin
         op_m1[i] = WIDTH'($urandom);
         op_m2[i] = WIDTH'($urandom);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 2'b00;
      req0_m1 = '0; req0_m2 = '0; req1_m1 = '0; req1_m2 = '0;
      res_ready = 1'b0;
      dp_quotient = '0;
      op_m1[0] = '0; op_m2[0] = '0; op_m1[1] = '0; op_m2[1] = '0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;
      @(negedge clk);

      op_m1[0] = 23'h400000; op_m2[0] = 23'h200000;
      run_divide(2'b01, 0, 0, "basic");

      op_m1[1] = 23'h000000; op_m2[1] = 23'h400000;
      run_divide(2'b10, 0, 0, "below_one");

      for (int i = 0; i < 4; i++) begin
         rand_ops();
         run_divide(2'b11, 0, 0, $sformatf("arb%0d", i));
      end

      rand_ops();
      run_divide(2'b01, 10, 0, "backpressure");

      rand_ops();
      run_divide(2'b10, 0, 4, "abort");
      rand_ops();
      run_divide(2'b11, 0, 0, "after_abort");

      op_m1[0] = '1; op_m2[0] = '0;
      op_m1[1] = 23'h123456; op_m2[1] = 23'h123456;
      run_divide(2'b01, 0, 0, "near_two");
      run_divide(2'b10, 1, 0, "exact_one");
      op_m1[0] = '0; op_m2[0] = '1;
      op_m1[1] = 23'h7FFFFE; op_m2[1] = 23'h7FFFFF;
      run_divide(2'b01, 0, 0, "near_half");
      run_divide(2'b10, 0, 0, "just_below_one");

      for (int i = 0; i < 12; i++) begin
         rand_ops();
         run_divide(2'($urandom_range(1, 3)), $urandom_range(0, 3), 0, $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
